bb_uart_tx_fifo: RTL and testbench
==================================

BB_UART_TX_FIFO -- requirements
Module: bb_uart_tx_fifo

Interface
REQ-001 Parameter DATA_W, 8, data bits per frame; legal range 5..9.
REQ-002 Parameter FIFO_DEPTH, 4, transmit FIFO entries; power of two, at least 2.
REQ-003 Parameter PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 Parameter STOP_BITS, 1, stop bits per frame; 1 or 2.
REQ-005 bdclk  in  1  baud clock, one rising edge per bit time.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 wr_en  in  1  write strobe; pushes wr_data into the FIFO.
REQ-008 wr_data  in  DATA_W  character to transmit.
REQ-009 full  out  1  FIFO holds FIFO_DEPTH entries.
REQ-010 empty  out  1  FIFO holds 0 entries.
REQ-011 level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-012 ovf  out  1  one-cycle pulse; a write was dropped.
REQ-013 txd  out  1  serial output; idle high.
REQ-014 txbsy  out  1  high while a frame is in progress.

Function
REQ-015 The block SHALL treat one bdclk cycle as exactly one bit time; all outputs are registered on bdclk.
REQ-016 The FSM SHALL have the states IDLE, START, DATA, PAR, and STOP; txbsy = (state != IDLE).
REQ-017 In IDLE with empty=0, the FSM SHALL pop the FIFO head into a shift register and enter START on the same edge, with txd=0 for that cycle.
REQ-018 In DATA, the FSM SHALL drive txd for DATA_W cycles, LSB first, one bit per cycle.
REQ-019 PAR SHALL last one cycle and SHALL be entered only when PARITY != 0; even parity = XOR of the data bits, odd parity = its inverse.
REQ-020 STOP SHALL drive txd=1 for STOP_BITS cycles.
REQ-021 Frame length SHALL be 1 + DATA_W + (PARITY != 0) + STOP_BITS cycles.
REQ-022 On the last STOP cycle, with empty=0, the FSM SHALL pop the FIFO and enter START directly, giving a back-to-back frame with no idle gap.
REQ-023 On the last STOP cycle, with empty=1, the FSM SHALL enter IDLE with txd=1 and txbsy=0.
REQ-024 A write at edge N into an empty FIFO while in IDLE SHALL produce the start bit from edge N+1.
REQ-025 A write with full=1 and no pop on the same edge SHALL be dropped: FIFO contents unchanged, ovf=1 for one cycle.
REQ-026 A write with full=1 and a pop on the same edge SHALL be accepted; level is unchanged.
REQ-027 A write with a pop on the same edge at any level SHALL leave level unchanged.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; level SHALL never exceed FIFO_DEPTH or go below 0.
REQ-029 wr_data SHALL be captured on the write edge; later changes to wr_data SHALL NOT affect the queued entry.

Reset
REQ-030 While rst=1 at a bdclk edge, the block SHALL set state=IDLE, txd=1, txbsy=0, ovf=0, level=0, empty=1, and full=0.
REQ-031 Reset mid-frame SHALL abort the frame (txd=1 from the next edge) and discard all queued data.
REQ-032 A wr_en in the same cycle as rst=1 SHALL be ignored.

Structure
REQ-033 Shared package bb_uart_pkg SHALL hold the parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD) and the FSM state encoding.
REQ-034 The FIFO SHALL be a separate sub-module, bb_sync_fifo, parametrised by width and depth, providing push, pop, full, empty, and level.
REQ-035 The top level SHALL contain the FSM, bit counter, and shift register only.

Verification
REQ-036 Defaults: write 0x55 while idle -> txd = 0,1,0,1,0,1,0,1,0,1 starting one cycle after the write, then idle high; txbsy high for exactly 10 cycles.
REQ-037 PARITY=1, STOP_BITS=2: write 0x07 -> start 0, bits 1,1,1,0,0,0,0,0, parity 1, stop 1,1; 12-cycle frame.
REQ-038 PARITY=2, DATA_W=7: write 0x00 -> parity bit 1; 10-cycle frame.
REQ-039 Burst: write 0xA1, 0xB2, 0xC3 on consecutive edges -> three frames back-to-back with no idle cycle; level peaks at 2 (the first entry is popped immediately after its write); empty=1 after the third pop.
REQ-040 Overflow: 5 writes with FIFO_DEPTH=4 while a frame is active -> the 5th write is dropped, ovf pulses once, and only the first 4 characters are sent.
REQ-041 Reset: assert rst in the 4th data bit of a frame with 2 characters queued -> txd=1, txbsy=0, level=0 next cycle, and no further frames are sent.

Source files
------------

// File: rtl/bb_uart_pkg.sv
// bb_uart_pkg: shared constants for the baud-clocked UART transmitter.
// Parity mode codes and the transmit FSM state encoding.
package bb_uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } tx_state_t;

    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/bb_sync_fifo.sv
// bb_sync_fifo: single-clock FIFO with occupancy count and drop pulse.
// A push into a full FIFO is accepted only when a pop shares the edge.
module bb_sync_fifo
    import bb_uart_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int LW    = level_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level,
    output logic          ovf
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] cnt_q;
    logic          ovf_q;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (cnt_q != '0);
    assign do_push = push && ((cnt_q != LW'(DEPTH)) || do_pop);

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (cnt_q == LW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign level = cnt_q;
    assign ovf   = ovf_q;

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            ovf_q <= push && !do_push;
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + LW'(1);
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - LW'(1);
            end
        end
    end

endmodule

// File: rtl/bb_uart_tx_fifo.sv
// bb_uart_tx_fifo: UART transmitter, one bdclk edge per bit time.
// Queues characters in a FIFO and sends frames back-to-back.
module bb_uart_tx_fifo
    import bb_uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                          bdclk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          ovf,
    output logic                          txd,
    output logic                          txbsy
);

    localparam int  CW      = 4;
    localparam bit  HAS_PAR = (PARITY != PAR_NONE);

    tx_state_t         state_q;
    logic [DATA_W-1:0] sh_q;
    logic [CW-1:0]     cnt_q;
    logic              par_q;
    logic              txd_q;

    logic [DATA_W-1:0] head;
    logic              pop;
    logic              last_stop;
    logic              par_bit;

    bb_sync_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH),
        .LW    ($clog2(FIFO_DEPTH) + 1)
    ) u_fifo (
        .clk   (bdclk),
        .rst   (rst),
        .push  (wr_en),
        .pop   (pop),
        .din   (wr_data),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level),
        .ovf   (ovf)
    );

    assign last_stop = (state_q == ST_STOP) && (cnt_q == CW'(STOP_BITS));
    assign pop       = !empty && ((state_q == ST_IDLE) || last_stop);
    assign par_bit   = (PARITY == PAR_ODD) ? ~^head : ^head;

    assign txd   = txd_q;
    assign txbsy = (state_q != ST_IDLE);

    // Frame sequencer: start, data LSB first, optional parity, stop.
    always_ff @(posedge bdclk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        sh_q    <= head;
                        par_q   <= par_bit;
                        state_q <= ST_START;
                        txd_q   <= 1'b0;
                    end else begin
                        txd_q   <= 1'b1;
                    end
                end
                ST_START: begin
                    state_q <= ST_DATA;
                    txd_q   <= sh_q[0];
                    sh_q    <= sh_q >> 1;
                    cnt_q   <= CW'(1);
                end
                ST_DATA: begin
                    if (cnt_q == CW'(DATA_W)) begin
                        if (HAS_PAR) begin
                            state_q <= ST_PAR;
                            txd_q   <= par_q;
                        end else begin
                            state_q <= ST_STOP;
                            txd_q   <= 1'b1;
                            cnt_q   <= CW'(1);
                        end
                    end else begin
                        txd_q <= sh_q[0];
                        sh_q  <= sh_q >> 1;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_PAR: begin
                    state_q <= ST_STOP;
                    txd_q   <= 1'b1;
                    cnt_q   <= CW'(1);
                end
                ST_STOP: begin
                    if (last_stop) begin
                        if (pop) begin
                            sh_q    <= head;
                            par_q   <= par_bit;
                            state_q <= ST_START;
                            txd_q   <= 1'b0;
                        end else begin
                            state_q <= ST_IDLE;
                            txd_q   <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                        txd_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    txd_q   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bb_uart_tx_fifo.sv
// tb_bb_uart_tx_fifo: directed checks of the UART transmitter FIFO.
// Three instances cover default, even/2-stop and odd/7-bit framing.
module tb_bb_uart_tx_fifo;

    logic       bdclk = 1'b0;
    logic       rst;
    logic [2:0] we;
    logic [7:0] wd0;
    logic [7:0] wd1;
    logic [6:0] wd2;
    logic [2:0] full;
    logic [2:0] empty;
    logic [2:0] ovf;
    logic [2:0] txd;
    logic [2:0] bsy;
    logic [2:0] lvl0;
    logic [2:0] lvl1;
    logic [2:0] lvl2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 bdclk = ~bdclk;

    bb_uart_tx_fifo u0 (
        .bdclk   (bdclk),
        .rst     (rst),
        .wr_en   (we[0]),
        .wr_data (wd0),
        .full    (full[0]),
        .empty   (empty[0]),
        .level   (lvl0),
        .ovf     (ovf[0]),
        .txd     (txd[0]),
        .txbsy   (bsy[0])
    );

    bb_uart_tx_fifo #(.PARITY(1), .STOP_BITS(2)) u1 (
        .bdclk   (bdclk),
        .rst     (rst),
        .wr_en   (we[1]),
        .wr_data (wd1),
        .full    (full[1]),
        .empty   (empty[1]),
        .level   (lvl1),
        .ovf     (ovf[1]),
        .txd     (txd[1]),
        .txbsy   (bsy[1])
    );

    bb_uart_tx_fifo #(.DATA_W(7), .PARITY(2)) u2 (
        .bdclk   (bdclk),
        .rst     (rst),
        .wr_en   (we[2]),
        .wr_data (wd2),
        .full    (full[2]),
        .empty   (empty[2]),
        .level   (lvl2),
        .ovf     (ovf[2]),
        .txd     (txd[2]),
        .txbsy   (bsy[2])
    );

    typedef struct {
        int         dut;
        logic [7:0] data;
        int         len;
        logic [0:11] exp;
    } vec_t;

    vec_t vt [7];

    logic [0:127] act;
    logic [0:127] actb;
    logic [0:127] acte;
    int           idx;
    int           peak;
    int           n_ovf;

    task automatic chk(input string name, input logic [127:0] got,
                       input logic [127:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h want 'h%0h", name, got, want);
        end
    endtask

    function automatic logic [0:9] frame8(input logic [7:0] d);
        logic [0:9] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        f[9] = 1'b1;
        return f;
    endfunction

    function automatic logic [2:0] lvl_of(input int k);
        case (k)
            0:       return lvl0;
            1:       return lvl1;
            default: return lvl2;
        endcase
    endfunction

    task automatic run_vec(input int vi, input vec_t v);
        @(negedge bdclk);
        we[v.dut] = 1'b1;
        wd0 = v.data;
        wd1 = v.data;
        wd2 = v.data[6:0];
        @(posedge bdclk);
        #1;
        we = '0;
        chk($sformatf("vec%0d_prebusy", vi), 128'(bsy[v.dut]), 128'(0));
        for (int i = 0; i < v.len; i++) begin
            @(posedge bdclk);
            #1;
            chk($sformatf("vec%0d_txd%0d", vi, i),
                128'(txd[v.dut]), 128'(v.exp[i]));
            chk($sformatf("vec%0d_bsy%0d", vi, i),
                128'(bsy[v.dut]), 128'(1));
        end
        @(posedge bdclk);
        #1;
        chk($sformatf("vec%0d_idle_txd", vi), 128'(txd[v.dut]), 128'(1));
        chk($sformatf("vec%0d_idle_bsy", vi), 128'(bsy[v.dut]), 128'(0));
    endtask

    task automatic step(input logic w, input logic [7:0] d, input logic r);
        @(negedge bdclk);
        we[0] = w;
        wd0   = d;
        rst   = r;
        @(posedge bdclk);
        #1;
        we[0] = 1'b0;
        rst   = 1'b0;
        act[idx]  = txd[0];
        actb[idx] = bsy[0];
        acte[idx] = empty[0];
        idx++;
        if (int'(lvl0) > peak) peak = int'(lvl0);
        if (ovf[0]) n_ovf++;
    endtask

    logic [0:34] exp_burst;
    logic [0:34] exp_bbsy;
    logic [0:69] exp_ovf;
    logic [0:5]  exp_rst;
    int          bad;

    initial begin
        vt[0] = '{0, 8'h55, 10, 12'b010101010100};
        vt[1] = '{0, 8'h00, 10, 12'b000000000100};
        vt[2] = '{0, 8'hA1, 10, 12'b010000101100};
        vt[3] = '{1, 8'h07, 12, 12'b011100000111};
        vt[4] = '{1, 8'h5A, 12, 12'b001011010011};
        vt[5] = '{2, 8'h00, 10, 12'b000000001100};
        vt[6] = '{2, 8'h7F, 10, 12'b011111110100};

        act  = '0;
        actb = '0;
        acte = '0;
        idx  = 0;
        peak = 0;
        n_ovf = 0;

        // reset, with a write that must be ignored
        rst = 1'b1;
        we  = 3'b001;
        wd0 = 8'hAA;
        wd1 = 8'h00;
        wd2 = 7'h00;
        repeat (3) @(posedge bdclk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_txd%0d", k), 128'(txd[k]), 128'(1));
            chk($sformatf("rst_bsy%0d", k), 128'(bsy[k]), 128'(0));
            chk($sformatf("rst_ovf%0d", k), 128'(ovf[k]), 128'(0));
            chk($sformatf("rst_full%0d", k), 128'(full[k]), 128'(0));
            chk($sformatf("rst_empty%0d", k), 128'(empty[k]), 128'(1));
            chk($sformatf("rst_lvl%0d", k), 128'(lvl_of(k)), 128'(0));
        end
        @(negedge bdclk);
        rst = 1'b0;
        we  = '0;
        repeat (2) @(posedge bdclk);
        #1;
        chk("rst_wr_ignored_lvl", 128'(lvl0), 128'(0));
        chk("rst_wr_ignored_bsy", 128'(bsy[0]), 128'(0));

        // table of single frames
        for (int i = 0; i < 7; i++) run_vec(i, vt[i]);

        // burst of three back-to-back characters
        exp_burst = {1'b1, frame8(8'hA1), frame8(8'hB2),
                     frame8(8'hC3), 4'hF};
        exp_bbsy  = {1'b0, 30'h3FFFFFFF, 4'h0};
        idx = 0;
        peak = 0;
        step(1'b1, 8'hA1, 1'b0);
        step(1'b1, 8'hB2, 1'b0);
        step(1'b1, 8'hC3, 1'b0);
        while (idx < 35) step(1'b0, 8'h00, 1'b0);
        chk("burst_txd", 128'(act[0:34]), 128'(exp_burst));
        chk("burst_bsy", 128'(actb[0:34]), 128'(exp_bbsy));
        chk("burst_peak", 128'(peak), 128'(2));
        chk("burst_empty_before", 128'(acte[20]), 128'(0));
        chk("burst_empty_after", 128'(acte[21]), 128'(1));

        // overflow while a frame is active, then write-on-pop when full
        exp_ovf = {1'b1, frame8(8'h11), frame8(8'h22), frame8(8'h33),
                   frame8(8'h44), frame8(8'h55), frame8(8'h77), 9'h1FF};
        idx = 0;
        n_ovf = 0;
        step(1'b1, 8'h11, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        step(1'b1, 8'h44, 1'b0);
        step(1'b1, 8'h55, 1'b0);
        chk("ovf_full", 128'(full[0]), 128'(1));
        chk("ovf_lvl4", 128'(lvl0), 128'(4));
        chk("ovf_pre_pulse", 128'(ovf[0]), 128'(0));
        step(1'b1, 8'h66, 1'b0);
        chk("ovf_pulse", 128'(ovf[0]), 128'(1));
        chk("ovf_lvl_kept", 128'(lvl0), 128'(4));
        repeat (4) step(1'b0, 8'h00, 1'b0);
        chk("ovf_pulse_gone", 128'(ovf[0]), 128'(0));
        step(1'b1, 8'h77, 1'b0);
        chk("full_wr_pop_lvl", 128'(lvl0), 128'(4));
        chk("full_wr_pop_ovf", 128'(ovf[0]), 128'(0));
        while (idx < 70) step(1'b0, 8'h00, 1'b0);
        chk("ovf_stream", 128'(act[0:69]), 128'(exp_ovf));
        chk("ovf_count", 128'(n_ovf), 128'(1));

        // reset in the 4th data bit with two characters queued
        exp_rst = 6'b101111;
        idx = 0;
        step(1'b1, 8'h0F, 1'b0);
        step(1'b1, 8'h12, 1'b0);
        step(1'b1, 8'h34, 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b0);
        chk("rstmid_frame_head", 128'(act[0:5]), 128'(exp_rst));
        chk("rstmid_lvl_before", 128'(lvl0), 128'(2));
        step(1'b0, 8'h00, 1'b1);
        chk("rstmid_txd", 128'(txd[0]), 128'(1));
        chk("rstmid_bsy", 128'(bsy[0]), 128'(0));
        chk("rstmid_lvl", 128'(lvl0), 128'(0));
        bad = 0;
        repeat (30) begin
            step(1'b0, 8'h00, 1'b0);
            if (txd[0] !== 1'b1 || bsy[0] !== 1'b0) bad++;
        end
        chk("rstmid_no_frames", 128'(bad), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
